serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract controller that time-shares a single full-adder cell across all bit positions of WIDTH-bit operands. It accepts a start request and captures the operands. It then steps the one full-adder cell LSB-first, one bit per clock, with a registered carry, and returns the sum, carry-out and signed overflow with a one-cycle done pulse. It sits between the arithmetic datapath users and the full-adder cell, and trades WIDTH+1 cycles of latency for one adder cell instead of WIDTH.

## Interface
- WIDTH, 8: operand/result width in bits; legal range WIDTH >= 1.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately.
- start  input  1  operation request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, high while in DONE.
- sum  output  WIDTH  result; registered, held until next completion.
- cout  output  1  carry-out of MSB (for sub: 1 = no borrow, a >= b unsigned).
- ovf  output  1  two's-complement overflow of the operation.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1: load a_sh <= a_in and b_sh <= (sub ? ~b_in : b_in); carry <= sub; bit counter <= 0; go to RUN. With start=0, stay in IDLE.
- RUN, each cycle: the full-adder cell takes a_sh[0], b_sh[0] and carry.
  - s_bit shifts into the MSB of the result shift register; a_sh and b_sh shift right by 1; carry <= c_bit; counter increments.
  - On the cycle with counter = WIDTH-1 (the last bit): sum <= final shifted result; cout <= c_bit; ovf <= carry XOR c_bit (carry into MSB XOR carry out). Then go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start in RUN or DONE is ignored. a_in/b_in/sub changes after capture have no effect on the operation in progress.
- sum/cout/ovf change only at the completion edge. They hold their previous values through IDLE and RUN.
- All arithmetic is modulo 2^WIDTH. The counter width is $clog2(WIDTH+1). WIDTH=1 gives a single RUN cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers, carry and counter cleared.
- Deassertion of rst_n takes effect at the next clk edge.
- Reset mid-RUN or in DONE aborts the operation. No done pulse follows and the outputs read 0.
- Latency: start accepted at edge E. busy=1 from E to E+WIDTH. sum/cout/ovf are valid and done=1 from E+WIDTH to E+WIDTH+1. The block is back in IDLE at E+WIDTH+1.
- Throughput: with start held high, one operation every WIDTH+2 cycles. Start in DONE is ignored, and the next accept happens at the first IDLE edge.
- busy and done are never high together. done is never high for two consecutive cycles.

## Test plan
- Reset: hold rst_n=0, toggle clk -> busy=0, done=0, sum=0x00, cout=0, ovf=0. Assert rst_n=0 asynchronously between edges -> outputs clear without a clk edge.
- WIDTH=8, a_in=0x5A, b_in=0x3C, sub=0, start pulsed 1 cycle -> busy for 8 cycles, then done pulse; sum=0x96, cout=0, ovf=1.
- a_in=0xFF, b_in=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a_in=0x7F, b_in=0x01 -> sum=0x80, cout=0, ovf=1.
- sub=1, a_in=0x10, b_in=0x20 -> sum=0xF0, cout=0, ovf=0. Then sub=1, a_in=0x80, b_in=0x01 -> sum=0x7F, cout=1, ovf=1.
- start held high continuously, with a_in/b_in changed every cycle during RUN:
  - each result matches the operands sampled at accept;
  - done pulses are exactly 10 cycles apart;
  - start during DONE does not cause an accept.
- rst_n=0 on the 4th RUN cycle of 0x5A+0x3C -> no done pulse, outputs 0. After release, a_in=0x01, b_in=0x02 -> sum=0x03, cout=0, ovf=0 with normal latency.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped LSB-first
// across WIDTH bit positions with a registered carry. Result, carry-out and
// signed overflow are published at completion with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit, c_bit, last_bit;
  logic [WIDTH-1:0] res_nxt;

  // Full-adder cell and the next value of the result shift register.
  // Shift-then-overwrite-MSB keeps WIDTH=1 legal (no [WIDTH-1:1] slice).
  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_bit    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last_bit = (cnt == CW'(WIDTH - 1));
    res_nxt  = res_sh >> 1;
    res_nxt[WIDTH-1] = s_bit;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial stepping and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= sub ? ~b_in : b_in;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          carry  <= c_bit;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= c_bit;
            ovf  <= carry ^ c_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 11'b0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation; start pulsed for one cycle, latency and results checked.
  task automatic do_op(input string name, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] e_sum,
                       input logic e_cout, input logic e_ovf);
    int n;
    @(negedge clk);
    start = 1'b1; sub = s; a_in = a; b_in = b;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_at_accept: busy=%b expected 1", name, busy);
    end
    @(negedge clk);
    start = 1'b0; sub = ~s; a_in = ~a; b_in = ~b;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != W) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles, expected %0d", name, n, W);
    end
    checks++;
    if (sum !== e_sum || cout !== e_cout || ovf !== e_ovf || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b busy=%b, expected sum=%h cout=%b ovf=%b busy=0",
               name, sum, cout, ovf, busy, e_sum, e_cout, e_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== e_sum) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b sum=%h, expected done=0 busy=0 sum=%h",
               name, done, busy, sum, e_sum);
    end
  endtask

  task automatic test_add();
    do_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    do_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    do_op("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    do_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
  endtask

  // Async assertion between edges must clear outputs with no clk edge.
  task automatic test_async_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 11'b0) begin
      errors++;
      $display("FAIL async_reset: sum=%h cout=%b ovf=%b, expected 0 0 0", sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] op_a(input int j);
    return W'(j * 37 + 5);
  endfunction
  function automatic logic [W-1:0] op_b(input int j);
    return W'(j * 91 + 3);
  endfunction
  function automatic logic op_s(input int j);
    return 1'((j + j / 10) & 1);
  endfunction

  // start held high, operands change every cycle; accepts at edges 0,10,20.
  task automatic test_back_to_back();
    logic [W-1:0] ea, eb, e_sum;
    logic         es, e_cout, e_ovf;
    logic [W:0]   full;
    int           ph;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      start = 1'b1; a_in = op_a(j); b_in = op_b(j); sub = op_s(j);
      @(posedge clk); #1;
      ph = j % 10;
      checks++;
      if (busy !== (ph < 8) || done !== (ph == 8)) begin
        errors++;
        $display("FAIL b2b_status_edge%0d: busy=%b done=%b, expected busy=%b done=%b",
                 j, busy, done, ph < 8, ph == 8);
      end
      if (ph == 8) begin
        ea = op_a(j - 8); eb = op_b(j - 8); es = op_s(j - 8);
        if (es) eb = ~eb;
        full   = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, es};
        e_sum  = full[W-1:0];
        e_cout = full[W];
        e_ovf  = (ea[W-1] == eb[W-1]) && (e_sum[W-1] != ea[W-1]);
        checks++;
        if (sum !== e_sum || cout !== e_cout || ovf !== e_ovf) begin
          errors++;
          $display("FAIL b2b_result_edge%0d: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   j, sum, cout, ovf, e_sum, e_cout, e_ovf);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Reset on the 4th RUN cycle aborts; no done pulse; next op is normal.
  task automatic test_abort();
    int seen;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a_in = 8'h5A; b_in = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 11'b0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy, sum, cout, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || sum !== 8'h00) begin
      errors++;
      $display("FAIL abort_no_done: activity cycles=%0d sum=%h, expected 0 and 00", seen, sum);
    end
    do_op("after_abort", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_async_reset();
    test_sub();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
